// File: rtl/fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : fir_sample_feeder
//  Purpose  : Input-side stage in front of the FIR tap sequencer. Samples
//             from a valid/ready source are buffered in a small synchronous
//             FIFO and released to the FIR datapath as a registered one-cycle
//             `load` pulse. Consecutive pulses are spaced ISSUE_INTERVAL
//             cycles apart, so each load lands when the sequencer is idle or
//             in its final tap cycle.
//  Ports    :
//     clk         in   clock, rising edge
//     rst         in   asynchronous reset, active-low
//     in_data     in   sample from upstream source
//     in_valid    in   in_data valid
//     in_ready    out  FIFO can accept (transfer on in_valid & in_ready)
//     load        out  registered one-cycle issue pulse to the sequencer
//     sample_out  out  registered sample, valid with load, held otherwise
//     fifo_count  out  FIFO occupancy, 0..DEPTH
//     busy        out  FIFO non-empty or cooldown still running
//  Revision : 1.0  initial release
// ============================================================================
module fir_sample_feeder #(
   parameter int DATA_WIDTH     = 16,
   parameter int DEPTH          = 8,   // power of 2, >= 2
   parameter int ISSUE_INTERVAL = 4    // FIR tap count, >= 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic                    load,
   output logic [DATA_WIDTH-1:0]   sample_out,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic                    busy
);

   // -------------------------------------------------------------------------
   // Derived widths and constants
   // -------------------------------------------------------------------------
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   // Cooldown holds values 0..ISSUE_INTERVAL-1; keep at least one bit so the
   // ISSUE_INTERVAL = 1 configuration still elaborates cleanly.
   localparam int CD_W  = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;

   localparam logic [CNT_W-1:0] C_DEPTH        = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] C_CNT_ONE      = CNT_W'(1);
   localparam logic [PTR_W-1:0] C_PTR_ONE      = PTR_W'(1);
   localparam logic [CD_W-1:0]  C_CD_ONE       = CD_W'(1);
   localparam logic [CD_W-1:0]  C_CD_RELOAD    = CD_W'(ISSUE_INTERVAL - 1);
   localparam bit               C_INTERVAL_ONE = (ISSUE_INTERVAL == 1);

   // -------------------------------------------------------------------------
   // Issue state machine encoding
   // -------------------------------------------------------------------------
   typedef enum logic [0:0] {
      ST_READY    = 1'b0,
      ST_COOLDOWN = 1'b1
   } state_t;

   // -------------------------------------------------------------------------
   // Registered state
   // -------------------------------------------------------------------------
   state_t                 r_state;
   logic [PTR_W-1:0]       r_wr_ptr;
   logic [PTR_W-1:0]       r_rd_ptr;
   logic [CNT_W-1:0]       r_count;
   logic [CD_W-1:0]        r_cooldown;
   logic                   r_load;
   logic [DATA_WIDTH-1:0]  r_sample;

   // FIFO storage is intentionally not reset; contents are don't-care until
   // written, and the occupancy count guards every read.
   logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

   // -------------------------------------------------------------------------
   // Next-state values
   // -------------------------------------------------------------------------
   state_t                 w_state_nxt;
   logic [PTR_W-1:0]       w_wr_ptr_nxt;
   logic [PTR_W-1:0]       w_rd_ptr_nxt;
   logic [CNT_W-1:0]       w_count_nxt;
   logic [CD_W-1:0]        w_cooldown_nxt;
   logic                   w_load_nxt;
   logic [DATA_WIDTH-1:0]  w_sample_nxt;

   logic                   w_in_ready;
   logic                   w_push;
   logic                   w_issue;

   // in_ready comes only from the registered count. A pop in the same cycle
   // does not open a slot when full; this keeps in_ready off the issue path.
   assign w_in_ready = (r_count < C_DEPTH);
   assign w_push     = in_valid & w_in_ready;

   // Issue whenever the sequencer-side spacing allows and data is present.
   assign w_issue    = (r_state == ST_READY) && (r_count != '0);

   // -------------------------------------------------------------------------
   // Next-state / output logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_wr_ptr_nxt   = r_wr_ptr;
      w_rd_ptr_nxt   = r_rd_ptr;
      w_count_nxt    = r_count;
      w_cooldown_nxt = r_cooldown;
      w_load_nxt     = 1'b0;
      w_sample_nxt   = r_sample;

      // Write side: pointer wraps naturally because DEPTH is a power of 2.
      if (w_push) begin
         w_wr_ptr_nxt = r_wr_ptr + C_PTR_ONE;
      end

      // Occupancy: a simultaneous push and pop leaves the count unchanged.
      unique case ({w_push, w_issue})
         2'b10:   w_count_nxt = r_count + C_CNT_ONE;
         2'b01:   w_count_nxt = r_count - C_CNT_ONE;
         default: w_count_nxt = r_count;
      endcase

      unique case (r_state)
         ST_READY: begin
            if (w_issue) begin
               w_load_nxt     = 1'b1;
               w_sample_nxt   = r_mem[r_rd_ptr];
               w_rd_ptr_nxt   = r_rd_ptr + C_PTR_ONE;
               w_cooldown_nxt = C_CD_RELOAD;
               // With a one-tap filter there is nothing to wait for.
               w_state_nxt    = C_INTERVAL_ONE ? ST_READY : ST_COOLDOWN;
            end
         end

         ST_COOLDOWN: begin
            // The countdown runs whether or not data is waiting, so a late
            // sample issues as soon as the spacing has elapsed. Returning to
            // READY on the edge the counter hits 0 makes the next issue land
            // exactly ISSUE_INTERVAL cycles after the previous one.
            if (r_cooldown != '0) begin
               w_cooldown_nxt = r_cooldown - C_CD_ONE;
            end
            if (r_cooldown <= C_CD_ONE) begin
               w_state_nxt = ST_READY;
            end
         end

         default: begin
            w_state_nxt    = ST_READY;
            w_cooldown_nxt = '0;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State register (asynchronous active-low reset)
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= ST_READY;
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_cooldown <= '0;
         r_load     <= 1'b0;
         r_sample   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_wr_ptr   <= w_wr_ptr_nxt;
         r_rd_ptr   <= w_rd_ptr_nxt;
         r_count    <= w_count_nxt;
         r_cooldown <= w_cooldown_nxt;
         r_load     <= w_load_nxt;
         r_sample   <= w_sample_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FIFO storage write port
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign in_ready   = w_in_ready;
   assign load       = r_load;
   assign sample_out = r_sample;
   assign fifo_count = r_count;
   assign busy       = (r_count != '0) || (r_cooldown != '0);

endmodule
`default_nettype wire

// File: tb/tb_fir_sample_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fir_sample_feeder
//  Purpose  : Self-checking bench for fir_sample_feeder. A queue-based model
//             tracks buffered samples and the cycle of the last issue; every
//             cycle the DUT outputs are compared against it. A small
//             behavioural FIR tap sequencer checks load alignment.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fir_sample_feeder;

   localparam int DW = 16;
   localparam int DEPTH = 8;
   localparam int N = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          load;
   logic [DW-1:0] sample_out;
   logic [3:0]    fifo_count;
   logic          busy;

   fir_sample_feeder #(
      .DATA_WIDTH     (DW),
      .DEPTH          (DEPTH),
      .ISSUE_INTERVAL (N)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .load       (load),
      .sample_out (sample_out),
      .fifo_count (fifo_count),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [DW-1:0] mq[$];
   int            cyc = 0;
   int            last_issue = -1000;
   int            n_written = 0;
   logic          exp_load = 1'b0;
   logic [DW-1:0] exp_sample = '0;
   logic [3:0]    exp_count = '0;
   logic          exp_ready = 1'b1;
   logic          exp_busy = 1'b0;

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural FIR tap sequencer ----------------
   logic seq_en = 1'b0;
   logic seq_active = 1'b0;
   int   seq_tap = 0;
   int   seq_valid = 0;
   int   seq_viol = 0;

   always @(posedge clk) begin
      if (seq_en) begin
         if (load) begin
            if (seq_active && seq_tap != N-1) seq_viol <= seq_viol + 1;
            if (seq_active && seq_tap == N-1) seq_valid <= seq_valid + 1;
            seq_active <= 1'b1;
            seq_tap    <= 0;
         end else if (seq_active) begin
            if (seq_tap == N-1) begin
               seq_active <= 1'b0;
               seq_valid  <= seq_valid + 1;
            end else begin
               seq_tap <= seq_tap + 1;
            end
         end
      end
   end

   task automatic model_reset();
      mq.delete();
      last_issue = -1000;
      exp_load   = 1'b0;
      exp_sample = '0;
      exp_count  = '0;
      exp_ready  = 1'b1;
      exp_busy   = 1'b0;
   endtask

   // Drive one cycle of input, advance the model across the edge, and leave
   // time 1 unit after the edge so outputs can be sampled.
   task automatic step(input logic v, input logic [DW-1:0] d);
      int   pre;
      logic acc;
      logic iss;
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      pre = mq.size();
      acc = v && (pre < DEPTH);
      iss = (pre != 0) && ((cyc - last_issue) >= N);
      exp_load = iss;
      if (iss) begin
         exp_sample = mq.pop_front();
         last_issue = cyc;
      end
      if (acc) begin
         mq.push_back(d);
         n_written++;
      end
      exp_count = 4'(mq.size());
      exp_ready = (mq.size() < DEPTH);
      exp_busy  = (mq.size() != 0) || ((cyc - last_issue) < N-1);
      cyc++;
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      in_valid = 1'b1;
      in_data = 16'hDEAD;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({load, sample_out, fifo_count, in_ready, busy} !== {1'b0, 16'h0, 4'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: load/sample/count/ready/busy got %b/%h/%0d/%b/%b want 0/0000/0/1/0",
                  load, sample_out, fifo_count, in_ready, busy);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, '0);
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL reset_idle c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 8; i++) begin
         step(i == 0, 16'h1234);
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL single c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
         if (i == 1) begin
            checks++;
            if (load !== 1'b1 || sample_out !== 16'h1234) begin
               errors++;
               $display("FAIL single_latency: load/sample got %b/%h want 1/1234", load, sample_out);
            end
         end
      end
   endtask

   task automatic test_burst();
      int min_ready = 1;
      for (int i = 0; i < 48; i++) begin
         step(i < 8, 16'(i + 1));
         if (i < 8 && in_ready !== 1'b1) min_ready = 0;
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL burst c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
      checks++;
      if (min_ready != 1) begin
         errors++;
         $display("FAIL burst_ready: in_ready dropped during burst got 0 want 1");
      end
   endtask

   task automatic test_overflow();
      int base = n_written;
      int peak = 0;
      int guard = 0;
      while ((n_written - base) < 12 && guard < 100) begin
         step(1'b1, 16'($urandom));
         guard++;
         if (int'(fifo_count) > peak) peak = int'(fifo_count);
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL overflow c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
      for (int i = 0; i < 50; i++) begin
         step(1'b0, '0);
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL overflow_drain c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
      checks++;
      if (peak != DEPTH || guard >= 100) begin
         errors++;
         $display("FAIL overflow_peak: peak count got %0d want %0d (cycles %0d)", peak, DEPTH, guard);
      end
   endtask

   // Writes land on the same edges as issues, so the count must hold steady
   // while both pointers advance through the wrap point.
   task automatic test_wrap_simultaneous();
      for (int i = 0; i < 70; i++) begin
         step((i == 0) || (i < 50 && (i % 4) == 1), 16'($urandom));
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL wrap c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 7; i++) begin
         step(1'b1, 16'h0A00 + 16'(i));
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL async_pre c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({load, sample_out, fifo_count, busy} !== {1'b0, 16'h0, 4'd0, 1'b0}) begin
         errors++;
         $display("FAIL async_immediate: load/sample/count/busy got %b/%h/%0d/%b want 0/0000/0/0",
                  load, sample_out, fifo_count, busy);
      end
      in_valid = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({load, fifo_count} !== {1'b0, 4'd0}) begin
         errors++;
         $display("FAIL async_hold: load/count got %b/%0d want 0/0", load, fifo_count);
      end
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      model_reset();
      for (int i = 0; i < 6; i++) begin
         step(i == 0, 16'hBEEF);
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL async_post c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
         if (i == 1) begin
            checks++;
            if (load !== 1'b1 || sample_out !== 16'hBEEF) begin
               errors++;
               $display("FAIL async_beef: load/sample got %b/%h want 1/beef", load, sample_out);
            end
         end
      end
   endtask

   task automatic test_random();
      int pct;
      for (int i = 0; i < 480; i++) begin
         case ((i / 80) % 4)
            0:       pct = 90;
            1:       pct = 50;
            2:       pct = 20;
            default: pct = 5;
         endcase
         step($urandom_range(99) < pct, 16'($urandom));
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL random c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
      for (int i = 0; i < 40; i++) begin
         step(1'b0, '0);
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL random_drain c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
   endtask

   task automatic test_sequencer();
      int base_w = n_written;
      int base_v = seq_valid;
      int base_x = seq_viol;
      int guard = 0;
      seq_en = 1'b1;
      while ((n_written - base_w) < 20 && guard < 200) begin
         step(1'b1, 16'($urandom));
         guard++;
         checks++;
         if ({load, sample_out, fifo_count, in_ready, busy} !== {exp_load, exp_sample, exp_count, exp_ready, exp_busy}) begin
            errors++;
            $display("FAIL seq_stream c%0d: got %b/%h/%0d/%b/%b want %b/%h/%0d/%b/%b", cyc,
                     load, sample_out, fifo_count, in_ready, busy, exp_load, exp_sample, exp_count, exp_ready, exp_busy);
         end
      end
      for (int i = 0; i < 60; i++) step(1'b0, '0);
      checks++;
      if ((seq_viol - base_x) != 0) begin
         errors++;
         $display("FAIL seq_align: misaligned loads got %0d want 0", seq_viol - base_x);
      end
      checks++;
      if ((seq_valid - base_v) != (n_written - base_w) || guard >= 200) begin
         errors++;
         $display("FAIL seq_count: valid_out count got %0d want %0d", seq_valid - base_v, n_written - base_w);
      end
      seq_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_wrap_simultaneous();
      test_async_reset();
      test_random();
      test_sequencer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/fir_sample_feeder.md
Name: fir_sample_feeder

Overview:
- Input-side stage directly upstream of the FIR tap-sequencer FSM.
- Buffers incoming samples from a valid/ready source in a small synchronous FIFO.
- Presents them to the FIR datapath as a registered single-cycle `load` pulse with `sample_out` valid in the same cycle.
- Spaces the pulses so that each `load` lands when the sequencer is idle or in its final tap cycle, where a new load is accepted.

Parameters:
- DATA_WIDTH, 16, sample width in bits.
- DEPTH, 8, FIFO entries; must be a power of 2, ≥ 2.
- ISSUE_INTERVAL, 4, minimum cycles between consecutive `load` pulses; equals the FIR tap count; ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_data  in  DATA_WIDTH  sample from upstream source.
- in_valid  in  1  `in_data` valid.
- in_ready  out  1  FIFO can accept; transfer occurs when `in_valid` and `in_ready` are both 1.
- load  out  1  one-cycle issue pulse to the FIR sequencer; registered.
- sample_out  out  DATA_WIDTH  sample for the FIR shift register; registered, valid when `load` = 1, holds last issued value otherwise.
- fifo_count  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- busy  out  1  1 when `fifo_count` ≠ 0 or the cooldown counter ≠ 0.

Behaviour:
- Reset (rst = 0, async): read/write pointers = 0, `fifo_count` = 0, cooldown counter = 0, `load` = 0, `sample_out` = 0, state = READY. FIFO contents are don't-care. Reset mid-operation discards all buffered samples and any pending cooldown; no `load` is produced during reset.
- `in_ready` = (`fifo_count` < DEPTH), combinational from registered count. There is no full-bypass: when full, `in_ready` = 0 even if a pop occurs in the same cycle.
- Write: on a clock edge with `in_valid` & `in_ready`, store `in_data` at the write pointer; pointer increments modulo DEPTH (natural wrap).
- Issue condition, evaluated from registered state: state = READY and `fifo_count` ≠ 0.
- On an edge where the issue condition holds:
  - `load` ← 1, `sample_out` ← head entry.
  - Read pointer increments modulo DEPTH.
  - Cooldown counter ← ISSUE_INTERVAL−1.
  - State ← COOLDOWN, or stays READY if ISSUE_INTERVAL = 1.
- Otherwise `load` ← 0 and `sample_out` holds.
- State machine:
  - READY: waits for a non-empty FIFO, then issues as above.
  - COOLDOWN: counter decrements by 1 each cycle; when the counter reaches 0 the state returns to READY. Consecutive issues are therefore exactly ISSUE_INTERVAL cycles apart while data is available.
- Simultaneous write and issue in one cycle: `fifo_count` unchanged; both pointers advance.
- Latency: a sample written at edge E (FIFO previously empty, state READY) produces `load` = 1 after edge E+1, i.e. one cycle.
- Empty: no `load` is generated. The cooldown counter still runs to 0, so a sample arriving late issues as soon as it is in the FIFO and the cooldown has expired.
- Ordering: strict FIFO order; no sample is dropped or duplicated.
- `busy` is combinational from registered state.

Test Plan:
1. Reset, then single write of 0x1234 at edge E → `load` = 1 with `sample_out` = 0x1234 for exactly one cycle after E+1; `fifo_count` returns to 0; `busy` drops ISSUE_INTERVAL−1 cycles later.
2. Burst of 8 writes 0x0001..0x0008 on back-to-back cycles (DEPTH = 8, ISSUE_INTERVAL = 4) → `load` pulses exactly 4 cycles apart carrying 1..8 in order; `in_ready` never deasserts, because issuing frees space before the FIFO fills.
3. Hold off issue by streaming 12 writes continuously → `fifo_count` peaks at DEPTH, `in_ready` = 0 while full, no value lost; all 12 values issue in order.
4. Write exactly at the cycle the cooldown expires while another entry is being popped → `fifo_count` unchanged that cycle; pointer wrap past index 7 to 0 yields correct data.
5. Assert rst = 0 asynchronously mid-stream with 5 entries buffered and the cooldown at 2 → `load`, `sample_out`, and `fifo_count` go to 0 immediately; after release, a new write 0xBEEF issues after one cycle with no stale data.
6. Connect to the FIR sequencer FSM with a continuous stream → every `load` coincides with the sequencer in its idle or final-tap state; `valid_out` count equals the number of samples written.
